// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode constants and parameter legality check
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic bit fifo_params_ok(input int depth, input int afull_th, input int aempty_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTHxWIDTH storage, synchronous write, asynchronous read
module fifo_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with FWFT option,
// almost flags, write-while-full-with-read and sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 128,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             reset,
  sync_fifo_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (!fifo_params_ok(DEPTH, AFULL_TH, AEMPTY_TH) || (WIDTH < 1)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/threshold combination");
  end

  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             full, empty, rd_acc, wr_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign rd_acc = bus.rd_en & ~empty;
  // a full FIFO still accepts a write when the same cycle frees a slot
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    ovf_d = (bus.wr_en & full & ~rd_acc) | (ovf_q & ~bus.clr_err);
    udf_d = (bus.rd_en & empty) | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // memory is not reset, so mask the head word while nothing is stored
    assign bus.rd_data  = empty ? '0 : ram_rdata;
    assign bus.rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AFULL_TH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (standard and FWFT instances)
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_rd;
  bit         exp_rv, m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(DEPTH)) s_if ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(DEPTH)) f_if ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(2)) u_std (
    .clk(clk), .reset(reset), .bus(s_if));
  sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(2)) u_fwft (
    .clk(clk), .reset(reset), .bus(f_if));

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  // Drives one cycle on the standard FIFO and advances the queue model.
  task automatic drive_std(input bit wr, input logic [7:0] wd, input bit rd, input bit clr);
    bit racc, wacc;
    racc  = rd && (mq.size() != 0);
    wacc  = wr && ((mq.size() != DEPTH) || racc);
    m_ovf = (wr && (mq.size() == DEPTH) && !racc) || (m_ovf && !clr);
    m_udf = (rd && (mq.size() == 0)) || (m_udf && !clr);
    s_if.wr_en = wr; s_if.wr_data = wd; s_if.rd_en = rd; s_if.clr_err = clr;
    @(posedge clk); #1;
    exp_rv = racc;
    if (racc) exp_rd = mq.pop_front();
    if (wacc) mq.push_back(wd);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    s_if.wr_en = 0; s_if.wr_data = 0; s_if.rd_en = 0; s_if.clr_err = 0;
    f_if.wr_en = 0; f_if.wr_data = 0; f_if.rd_en = 0; f_if.clr_err = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    mq.delete(); exp_rd = 0; exp_rv = 0; m_ovf = 0; m_udf = 0;
    checks++; if (s_if.count !== 4'd0)      begin errors++; $display("FAIL reset_count got %0d exp 0", s_if.count); end
    checks++; if (s_if.empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b exp 1", s_if.empty); end
    checks++; if (s_if.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", s_if.almost_empty); end
    checks++; if (s_if.full !== 1'b0 || s_if.almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b exp 00", s_if.full, s_if.almost_full); end
    checks++; if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd got %b/%h exp 0/00", s_if.rd_valid, s_if.rd_data); end
    checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", s_if.overflow, s_if.underflow); end
    checks++; if (f_if.rd_valid !== 1'b0 || f_if.rd_data !== 8'h00 || f_if.empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got %b/%h/%b exp 0/00/1", f_if.rd_valid, f_if.rd_data, f_if.empty); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 8; i++) begin
      drive_std(1, 8'(i), 0, 0);
      checks++; if (s_if.count !== 4'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", s_if.count, i); end
      checks++; if (s_if.almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty at %0d got %b exp %b", i, s_if.almost_empty, (i <= 2)); end
      checks++; if (s_if.almost_full !== (i >= 6)) begin errors++; $display("FAIL fill_afull at %0d got %b exp %b", i, s_if.almost_full, (i >= 6)); end
    end
    checks++; if (s_if.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", s_if.full); end
    for (int i = 1; i <= 8; i++) begin
      drive_std(0, 8'h00, 1, 0);
      checks++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== 8'(i)) begin errors++; $display("FAIL drain_data got %b/%h exp 1/%h", s_if.rd_valid, s_if.rd_data, 8'(i)); end
    end
    drive_std(0, 8'h00, 0, 0);
    checks++; if (s_if.rd_valid !== 1'b0 || s_if.empty !== 1'b1) begin errors++; $display("FAIL drain_end got rv %b empty %b exp 0 1", s_if.rd_valid, s_if.empty); end
    checks++; if (s_if.rd_data !== 8'h08) begin errors++; $display("FAIL drain_hold got %h exp 08", s_if.rd_data); end
  endtask

  task automatic test_full_rw;
    logic [7:0] oldest;
    for (int i = 0; i < 8; i++) drive_std(1, 8'($urandom), 0, 0);
    oldest = mq[0];
    drive_std(1, 8'hAA, 1, 0);
    checks++; if (s_if.rd_data !== oldest || s_if.rd_valid !== 1'b1) begin errors++; $display("FAIL fullrw_data got %h exp %h", s_if.rd_data, oldest); end
    checks++; if (s_if.count !== 4'd8 || s_if.overflow !== 1'b0) begin errors++; $display("FAIL fullrw_count got %0d ovf %b exp 8 0", s_if.count, s_if.overflow); end
    drive_std(1, 8'h11, 0, 0);
    checks++; if (s_if.overflow !== 1'b1 || s_if.count !== 4'd8) begin errors++; $display("FAIL ovf_set got ovf %b count %0d exp 1 8", s_if.overflow, s_if.count); end
    drive_std(0, 8'h00, 0, 0);
    checks++; if (s_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", s_if.overflow); end
    drive_std(0, 8'h00, 0, 1);
    checks++; if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", s_if.overflow); end
    for (int i = 0; i < 8; i++) begin
      drive_std(0, 8'h00, 1, 0);
      checks++; if (s_if.rd_data !== exp_rd) begin errors++; $display("FAIL fullrw_drain got %h exp %h", s_if.rd_data, exp_rd); end
    end
    checks++; if (s_if.rd_data !== 8'hAA) begin errors++; $display("FAIL fullrw_last got %h exp aa", s_if.rd_data); end
  endtask

  task automatic test_empty_rw;
    drive_std(1, 8'h55, 1, 0);
    checks++; if (s_if.underflow !== 1'b1 || s_if.count !== 4'd1 || s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL emptyrw got udf %b count %0d rv %b exp 1 1 0", s_if.underflow, s_if.count, s_if.rd_valid); end
    drive_std(0, 8'h00, 1, 0);
    checks++; if (s_if.rd_data !== 8'h55 || s_if.rd_valid !== 1'b1) begin errors++; $display("FAIL emptyrw_read got %h exp 55", s_if.rd_data); end
    drive_std(1, 8'h01, 1, 1);
    checks++; if (s_if.underflow !== 1'b1) begin errors++; $display("FAIL udf_set_wins got %b exp 1", s_if.underflow); end
    drive_std(0, 8'h00, 1, 1);
    checks++; if (s_if.underflow !== 1'b0 || s_if.empty !== 1'b1) begin errors++; $display("FAIL udf_clr got %b empty %b exp 0 1", s_if.underflow, s_if.empty); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) drive_std(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive_std(1, 8'($urandom), 1, 0);
      checks++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== exp_rd || s_if.count !== 4'd4) begin errors++; $display("FAIL b2b cyc %0d got %b/%h/%0d exp 1/%h/4", i, s_if.rd_valid, s_if.rd_data, s_if.count, exp_rd); end
    end
    for (int i = 0; i < 4; i++) begin
      drive_std(0, 8'h00, 1, 0);
      checks++; if (s_if.rd_data !== exp_rd) begin errors++; $display("FAIL b2b_drain got %h exp %h", s_if.rd_data, exp_rd); end
    end
  endtask

  task automatic test_random;
    int wr_pct;
    for (int i = 0; i < 300; i++) begin
      wr_pct = (i < 100) ? 75 : (i < 200) ? 25 : 50;
      drive_std($urandom_range(0, 99) < wr_pct, 8'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 15) == 0);
      checks++; if (s_if.rd_valid !== exp_rv) begin errors++; $display("FAIL rand_rv cyc %0d got %b exp %b", i, s_if.rd_valid, exp_rv); end
      checks++; if (s_if.rd_data !== exp_rd) begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", i, s_if.rd_data, exp_rd); end
      checks++; if (s_if.count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", i, s_if.count, mq.size()); end
      checks++; if (s_if.full !== (mq.size() == DEPTH) || s_if.empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_fe cyc %0d got %b%b exp size %0d", i, s_if.full, s_if.empty, mq.size()); end
      checks++; if (s_if.almost_full !== (mq.size() >= 6) || s_if.almost_empty !== (mq.size() <= 2)) begin errors++; $display("FAIL rand_almost cyc %0d got %b%b exp size %0d", i, s_if.almost_full, s_if.almost_empty, mq.size()); end
      checks++; if (s_if.overflow !== m_ovf || s_if.underflow !== m_udf) begin errors++; $display("FAIL rand_err cyc %0d got %b%b exp %b%b", i, s_if.overflow, s_if.underflow, m_ovf, m_udf); end
    end
  endtask

  task automatic test_fwft;
    logic [7:0] fq[$];
    logic [7:0] wd;
    bit wr, rd, racc, wacc;
    f_if.wr_en = 1; f_if.wr_data = 8'h3C;
    @(posedge clk); #1;
    f_if.wr_en = 0;
    checks++; if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== 8'h3C) begin errors++; $display("FAIL fwft_show got %b/%h exp 1/3c", f_if.rd_valid, f_if.rd_data); end
    f_if.rd_en = 1;
    @(posedge clk); #1;
    f_if.rd_en = 0;
    checks++; if (f_if.empty !== 1'b1 || f_if.rd_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop got empty %b rv %b exp 1 0", f_if.empty, f_if.rd_valid); end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); wd = 8'($urandom);
      racc = rd && (fq.size() != 0);
      wacc = wr && ((fq.size() != DEPTH) || racc);
      f_if.wr_en = wr; f_if.wr_data = wd; f_if.rd_en = rd;
      @(posedge clk); #1;
      if (racc) void'(fq.pop_front());
      if (wacc) fq.push_back(wd);
      checks++; if (f_if.rd_valid !== (fq.size() != 0)) begin errors++; $display("FAIL fwft_rv cyc %0d got %b exp size %0d", i, f_if.rd_valid, fq.size()); end
      if (fq.size() != 0) begin
        checks++; if (f_if.rd_data !== fq[0]) begin errors++; $display("FAIL fwft_data cyc %0d got %h exp %h", i, f_if.rd_data, fq[0]); end
      end
    end
    f_if.wr_en = 0; f_if.rd_en = 0;
  endtask

  task automatic test_async_reset;
    drive_std(1, 8'h9A, 0, 0);
    drive_std(0, 8'h00, 1, 0);
    drive_std(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) drive_std(1, 8'($urandom), 0, 0);
    checks++; if (s_if.count !== 4'd5 || s_if.rd_data !== 8'h9A || s_if.underflow !== 1'b1) begin errors++; $display("FAIL arst_pre got %0d/%h/%b exp 5/9a/1", s_if.count, s_if.rd_data, s_if.underflow); end
    #3;
    reset = 1'b0;
    s_if.wr_en = 0; s_if.rd_en = 0; s_if.clr_err = 0;
    #1;
    checks++; if (s_if.count !== 4'd0 || s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin errors++; $display("FAIL arst_count got %0d e %b ae %b exp 0 1 1", s_if.count, s_if.empty, s_if.almost_empty); end
    checks++; if (s_if.full !== 1'b0 || s_if.almost_full !== 1'b0) begin errors++; $display("FAIL arst_full got %b%b exp 00", s_if.full, s_if.almost_full); end
    checks++; if (s_if.rd_data !== 8'h00 || s_if.rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd got %h/%b exp 00/0", s_if.rd_data, s_if.rd_valid); end
    checks++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin errors++; $display("FAIL arst_err got %b%b exp 00", s_if.overflow, s_if.underflow); end
    @(posedge clk); #1;
    reset = 1'b1;
    mq.delete(); exp_rd = 0; exp_rv = 0; m_ovf = 0; m_udf = 0;
    drive_std(1, 8'h77, 0, 0);
    drive_std(0, 8'h00, 1, 0);
    checks++; if (s_if.rd_data !== 8'h77 || s_if.rd_valid !== 1'b1 || s_if.empty !== 1'b1) begin errors++; $display("FAIL arst_after got %h/%b/%b exp 77/1/1", s_if.rd_data, s_if.rd_valid, s_if.empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_random();
    test_fwft();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO; next generation of the team's 64x128 synchronous FIFO. Adds configurable width and depth, a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, write-while-full with a simultaneous read, and sticky overflow/underflow error flags. Sits between any producer and consumer in the same clock domain.

## Interface
- `WIDTH`, 64: data word width in bits (≥1).
- `DEPTH`, 128: entry count; power of two, ≥2.
- `FWFT`, 0: 0 = standard registered-read mode, 1 = first-word-fall-through.
- `AFULL_TH`, DEPTH-4: `almost_full` when count ≥ AFULL_TH.
- `AEMPTY_TH`, 4: `almost_empty` when count ≤ AEMPTY_TH.
- `CW`, derived: `$clog2(DEPTH+1)`, count width.
- `clk  in  1`: sole clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset; assertion takes effect immediately, deassertion synchronous to `clk`.
- `wr_en  in  1`: write request.
- `wr_data  in  WIDTH`: write word.
- `rd_en  in  1`: read request (FWFT: pop/acknowledge).
- `clr_err  in  1`: synchronous clear of `overflow`/`underflow`.
- `rd_data  out  WIDTH`: read word.
- `rd_valid  out  1`: `rd_data` valid.
- `full  out  1`, `empty  out  1`, `almost_full  out  1`, `almost_empty  out  1`: status.
- `count  out  CW`: occupancy, 0..DEPTH.
- `overflow  out  1`, `underflow  out  1`: sticky error flags.

## Operation
- Accepted read `rd_acc = rd_en & ~empty`; accepted write `wr_acc = wr_en & (~full | rd_acc)`.
- Write while full with `rd_acc` is accepted; read while empty is never accepted, even with a simultaneous write.
- `wr_acc`: `mem[wptr] <= wr_data`, `wptr` increments. `rd_acc`: `rptr` increments. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH naturally.
- `count`: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
- `full = (count == DEPTH)`, `empty = (count == 0)`, almost flags compare against thresholds; all decoded from the registered `count`.
- Standard mode (FWFT=0): on rd_acc, `rd_data <= mem[rptr]` and `rd_valid` = 1 for the next cycle only; `rd_data` holds its last value otherwise.
- FWFT mode: `rd_data = mem[rptr]` and `rd_valid = ~empty`; `rd_en` pops the displayed word.
- `overflow` sets on `wr_en & full & ~rd_acc`. `underflow` sets on `rd_en & empty`. Both are sticky until `clr_err` or reset. If set and clear coincide, set wins.
- Rejected requests leave memory, pointers and count unchanged.
- Reset values: pointers 0, count 0, `rd_data` 0, `rd_valid` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0, `overflow` 0, `underflow` 0. Memory is not reset. Reset mid-operation discards all contents.

## Timing
- Standard mode read latency: 1 cycle from rd_acc edge to `rd_data`/`rd_valid`.
- FWFT: a word written into an empty FIFO appears on `rd_data` with `rd_valid` = 1 one cycle after the write edge.
- Status flags and `count` update on the same edge as the causing transfer.
- Back-to-back read and write are sustained every cycle at full throughput.

## Structure
- Shared package `fifo_pkg` holds the mode constants `FIFO_MODE_STD = 0` and `FIFO_MODE_FWFT = 1`, plus the parameter-legality check (DEPTH a power of two, AEMPTY_TH < AFULL_TH ≤ DEPTH). Shared by all FIFO variants.
- One sub-module `fifo_ram`: DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port. Pointers, count, flags and the read register live in the top level.

## Test plan
- Reset, then WIDTH=8/DEPTH=8/FWFT=0: write 0x01..0x08 → `full` = 1, `count` = 8. Read 8 times → 0x01..0x08, each 1 cycle after rd_en with a `rd_valid` pulse, then `empty` = 1.
- Full FIFO, `wr_en` = `rd_en` = 1 with data 0xAA → oldest word out, 0xAA accepted, `count` stays 8, `overflow` stays 0. Then `wr_en` alone → `overflow` = 1 and `count` = 8. `clr_err` → `overflow` = 0.
- Empty FIFO, `rd_en` = `wr_en` = 1 with 0x55 → read rejected, `underflow` = 1, `count` = 1. Next read returns 0x55.
- FWFT=1: write 0x3C into empty FIFO → next cycle `rd_valid` = 1 and `rd_data` = 0x3C with no rd_en. `rd_en` → `empty` = 1, `rd_valid` = 0.
- DEPTH=8, AFULL_TH=6, AEMPTY_TH=2: fill one word per cycle → `almost_empty` drops at count 3 and `almost_full` rises at count 6. Then 20 interleaved write/read cycles → data order preserved across pointer wrap.
- Assert `reset` low asynchronously mid-burst (count = 5) → all outputs take reset values before the next edge. After release, a write/read of 0x77 returns 0x77.
